// File: rtl/sim_ft2232_fifo_model_pkg.sv
// Shared types and helpers for the FT2232H 245 sync-FIFO device-side model.
package ft2232_sim_pkg;

  typedef enum logic {
    MODE_PATTERN  = 1'b0,
    MODE_LOOPBACK = 1'b1
  } mode_t;

  localparam int BYTE_W = 8;

  function automatic logic [BYTE_W-1:0] next_pattern(input logic [BYTE_W-1:0] cur);
    return cur + 8'd1;
  endfunction

endpackage

// File: rtl/sim_ft2232_fifo_model_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
module sim_byte_fifo #(
  parameter int DEPTH  = 512,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage is data only; a reset just empties the FIFO via the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sim_ft2232_fifo_model.sv
// Device-side model of the FT2232H 245 synchronous FIFO: pattern source/checker or loopback.
module sim_ft2232_fifo_model
  import ft2232_sim_pkg::*;
#(
  parameter int         RX_DEPTH     = 512,
  parameter int         TX_DEPTH     = 512,
  parameter int         MODE         = 0,
  parameter logic [7:0] SEED         = 8'h00,
  parameter int         DRAIN_DIV    = 4,
  parameter int         STALL_PERIOD = 0,
  parameter int         STALL_LEN    = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        ft2232_reset_n_i,
  input  logic        fifo_oe_n_i,
  input  logic        fifo_rd_n_i,
  input  logic        fifo_wr_n_i,
  input  logic        fifo_siwu_i,
  input  logic [7:0]  fifo_data_i,
  output logic [7:0]  fifo_data_o,
  output logic        fifo_data_oe_o,
  output logic        fifo_rxf_n_o,
  output logic        fifo_txe_n_o,
  output logic [31:0] rx_count_o,
  output logic [31:0] tx_count_o,
  output logic [15:0] mismatch_count_o,
  output logic        protocol_err_o
);

  localparam mode_t        MODE_SEL   = (MODE == 1) ? MODE_LOOPBACK : MODE_PATTERN;
  localparam int           RAW        = $clog2(RX_DEPTH);
  localparam int           TAW        = $clog2(TX_DEPTH);
  localparam logic [TAW:0] TX_HI      = (TAW+1)'(TX_DEPTH - 1);
  localparam logic [31:0]  DRAIN_LAST = 32'(DRAIN_DIV - 1);
  localparam logic [31:0]  STALL_LAST = (STALL_PERIOD > 0) ? 32'(STALL_PERIOD - 1) : 32'd0;
  localparam logic [31:0]  STALL_CYC  = 32'(STALL_LEN);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic rst;
  assign rst = reset_i || !ft2232_reset_n_i;

  // Send-immediate has no modelled effect.
  logic unused_siwu;
  assign unused_siwu = fifo_siwu_i;

  logic        rxf_n_q;
  logic        txe_n_q;
  logic        rst_dly_q;
  logic        protocol_err_q;
  logic [31:0] rx_count_q;
  logic [31:0] tx_count_q;
  logic [15:0] mismatch_q;
  logic [7:0]  pattern_q;
  logic [7:0]  expected_q;
  logic [31:0] stall_cnt_q;
  logic [31:0] stall_cnt_nxt;
  logic [31:0] drain_cnt_q;
  logic [31:0] drain_cnt_nxt;
  logic        stall_nxt;
  logic        drain_tick;

  logic         rx_push;
  logic         rx_pop;
  logic [7:0]   rx_din;
  logic [7:0]   rx_head;
  logic         rx_full;
  logic         rx_empty;
  logic [RAW:0] rx_occ;
  logic [RAW:0] rx_occ_nxt;

  logic         tx_push;
  logic         tx_pop;
  logic [7:0]   tx_head;
  logic         tx_full;
  logic         tx_empty;
  logic [TAW:0] tx_occ;
  logic [TAW:0] tx_occ_nxt;

  logic rd_fire;
  logic wr_fire;
  logic proto_viol;

  sim_byte_fifo #(.DEPTH(RX_DEPTH), .DATA_W(8)) u_rx_fifo (
    .clk       (clk_i),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_din),
    .pop       (rx_pop),
    .head      (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_occ)
  );

  sim_byte_fifo #(.DEPTH(TX_DEPTH), .DATA_W(8)) u_tx_fifo (
    .clk       (clk_i),
    .rst       (rst),
    .push      (tx_push),
    .push_data (fifo_data_i),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_occ)
  );

  // rxf_n low already implies the RX FIFO holds at least one byte.
  assign rd_fire    = !fifo_oe_n_i && !fifo_rd_n_i && !rxf_n_q;
  assign wr_fire    = !fifo_wr_n_i && !txe_n_q && fifo_oe_n_i && !tx_full;
  assign proto_viol = (!fifo_rd_n_i && fifo_oe_n_i) ||
                      (!fifo_wr_n_i && !fifo_oe_n_i) ||
                      (!fifo_rd_n_i && !fifo_wr_n_i);

  assign drain_tick = (drain_cnt_q == DRAIN_LAST);
  assign tx_push    = wr_fire;
  assign tx_pop     = drain_tick && !tx_empty && ((MODE_SEL == MODE_PATTERN) || !rx_full);
  assign rx_push    = (MODE_SEL == MODE_PATTERN) ? !rx_full : tx_pop;
  assign rx_din     = (MODE_SEL == MODE_PATTERN) ? pattern_q : tx_head;
  assign rx_pop     = rd_fire;

  assign rx_occ_nxt = rx_occ + (RAW+1)'(rx_push) - (RAW+1)'(rx_pop);
  assign tx_occ_nxt = tx_occ + (TAW+1)'(tx_push) - (TAW+1)'(tx_pop);

  always_comb begin
    stall_cnt_nxt = 32'd0;
    if (stall_cnt_q != STALL_LAST) stall_cnt_nxt = stall_cnt_q + 32'd1;
    drain_cnt_nxt = 32'd0;
    if (!drain_tick) drain_cnt_nxt = drain_cnt_q + 32'd1;
  end

  // Flags are registered from the post-edge state so they match the next cycle.
  assign stall_nxt = (STALL_PERIOD > 0) && (stall_cnt_nxt < STALL_CYC);

  always_ff @(posedge clk_i) begin
    rst_dly_q <= rst;
    if (rst) begin
      rxf_n_q        <= 1'b1;
      txe_n_q        <= 1'b1;
      protocol_err_q <= 1'b0;
      rx_count_q     <= 32'd0;
      tx_count_q     <= 32'd0;
      mismatch_q     <= 16'd0;
      pattern_q      <= SEED;
      expected_q     <= SEED;
      stall_cnt_q    <= 32'd0;
      drain_cnt_q    <= 32'd0;
    end else begin
      rxf_n_q     <= (rx_occ_nxt == '0);
      txe_n_q     <= (tx_occ_nxt >= TX_HI) || stall_nxt;
      stall_cnt_q <= stall_cnt_nxt;
      drain_cnt_q <= drain_cnt_nxt;
      if (rx_push && (MODE_SEL == MODE_PATTERN)) pattern_q <= next_pattern(pattern_q);
      if (rd_fire) rx_count_q <= rx_count_q + 32'd1;
      if (wr_fire) tx_count_q <= tx_count_q + 32'd1;
      // On a match head equals expected, so head+1 covers both match and resync.
      if (tx_pop && (MODE_SEL == MODE_PATTERN)) begin
        if (tx_head != expected_q) mismatch_q <= sat_inc16(mismatch_q);
        expected_q <= next_pattern(tx_head);
      end
      if (proto_viol) protocol_err_q <= 1'b1;
    end
  end

  assign fifo_data_oe_o   = !fifo_oe_n_i && !rst_dly_q;
  assign fifo_data_o      = rx_empty ? 8'h00 : rx_head;
  assign fifo_rxf_n_o     = rxf_n_q;
  assign fifo_txe_n_o     = txe_n_q;
  assign rx_count_o       = rx_count_q;
  assign tx_count_o       = tx_count_q;
  assign mismatch_count_o = mismatch_q;
  assign protocol_err_o   = protocol_err_q;

endmodule

// File: tb/tb_sim_ft2232_fifo_model.sv
// Bench: three model instances (pattern SEED 10h, pattern SEED 00h, stalled loopback).
module tb_sim_ft2232_fifo_model;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  logic        ft_rst_n [3];
  logic        oe_n [3];
  logic        rd_n [3];
  logic        wr_n [3];
  logic        siwu [3];
  logic [7:0]  din [3];
  logic [7:0]  dout [3];
  logic        doe [3];
  logic        rxf_n [3];
  logic        txe_n [3];
  logic [31:0] rxc [3];
  logic [31:0] txc [3];
  logic [15:0] mmc [3];
  logic        perr [3];

  sim_ft2232_fifo_model #(.RX_DEPTH(16), .TX_DEPTH(16), .MODE(0), .SEED(8'h10),
                          .DRAIN_DIV(4), .STALL_PERIOD(0), .STALL_LEN(0)) u_dut_a (
    .clk_i(clk), .reset_i(rst[0]), .ft2232_reset_n_i(ft_rst_n[0]),
    .fifo_oe_n_i(oe_n[0]), .fifo_rd_n_i(rd_n[0]), .fifo_wr_n_i(wr_n[0]),
    .fifo_siwu_i(siwu[0]), .fifo_data_i(din[0]), .fifo_data_o(dout[0]),
    .fifo_data_oe_o(doe[0]), .fifo_rxf_n_o(rxf_n[0]), .fifo_txe_n_o(txe_n[0]),
    .rx_count_o(rxc[0]), .tx_count_o(txc[0]), .mismatch_count_o(mmc[0]),
    .protocol_err_o(perr[0]));

  sim_ft2232_fifo_model #(.RX_DEPTH(16), .TX_DEPTH(16), .MODE(0), .SEED(8'h00),
                          .DRAIN_DIV(4), .STALL_PERIOD(0), .STALL_LEN(0)) u_dut_b (
    .clk_i(clk), .reset_i(rst[1]), .ft2232_reset_n_i(ft_rst_n[1]),
    .fifo_oe_n_i(oe_n[1]), .fifo_rd_n_i(rd_n[1]), .fifo_wr_n_i(wr_n[1]),
    .fifo_siwu_i(siwu[1]), .fifo_data_i(din[1]), .fifo_data_o(dout[1]),
    .fifo_data_oe_o(doe[1]), .fifo_rxf_n_o(rxf_n[1]), .fifo_txe_n_o(txe_n[1]),
    .rx_count_o(rxc[1]), .tx_count_o(txc[1]), .mismatch_count_o(mmc[1]),
    .protocol_err_o(perr[1]));

  sim_ft2232_fifo_model #(.RX_DEPTH(64), .TX_DEPTH(64), .MODE(1), .SEED(8'h00),
                          .DRAIN_DIV(2), .STALL_PERIOD(16), .STALL_LEN(4)) u_dut_c (
    .clk_i(clk), .reset_i(rst[2]), .ft2232_reset_n_i(ft_rst_n[2]),
    .fifo_oe_n_i(oe_n[2]), .fifo_rd_n_i(rd_n[2]), .fifo_wr_n_i(wr_n[2]),
    .fifo_siwu_i(siwu[2]), .fifo_data_i(din[2]), .fifo_data_o(dout[2]),
    .fifo_data_oe_o(doe[2]), .fifo_rxf_n_o(rxf_n[2]), .fifo_txe_n_o(txe_n[2]),
    .rx_count_o(rxc[2]), .tx_count_o(txc[2]), .mismatch_count_o(mmc[2]),
    .protocol_err_o(perr[2]));

  typedef struct {
    logic oe_n;
    logic rd_n;
    logic wr_n;
    logic err;
  } pvec_t;

  pvec_t       pv [8];
  int          n_vec = 0;
  int          n_mis = 0;
  logic [7:0]  exp_q [$];
  logic [7:0]  wr_q [$];
  int          c_phase = 0;
  bit          c_chk = 1'b0;
  bit          saw_hi;
  int          acc_at_hi;
  logic [7:0]  m_exp;
  logic [15:0] m_mm;
  logic [31:0] m_txn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // One clock; also tracks the stall-window phase of the loopback instance.
  task automatic tick();
    @(posedge clk);
    #1;
    c_phase = (c_phase + 1) % 16;
    if (c_chk && c_phase < 4) chk("stall_txe", 32'(txe_n[2]), 32'd1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int d);
    rst[d] = 1'b1;
    ticks(2);
    rst[d] = 1'b0;
  endtask

  task automatic model_tx(input logic [7:0] b);
    if (b != m_exp) m_mm = (m_mm == 16'hFFFF) ? m_mm : m_mm + 16'd1;
    m_exp = b + 8'd1;
    m_txn = m_txn + 32'd1;
  endtask

  task automatic read_bytes(input int d, input int n, input bit rnd);
    int got = 0;
    int guard = 0;
    oe_n[d] = 1'b0;
    while (got < n && guard < 2000) begin
      rd_n[d] = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
      #1;
      if (!rd_n[d] && !rxf_n[d]) begin
        chk("rd_data", 32'(dout[d]), 32'(exp_q.pop_front()));
        got++;
      end
      tick();
      guard++;
    end
    rd_n[d] = 1'b1;
    if (got < n) chk("rd_timeout", got, n);
  endtask

  task automatic write_q(input int d);
    int guard = 0;
    int acc = 0;
    oe_n[d] = 1'b1;
    rd_n[d] = 1'b1;
    while (wr_q.size() > 0 && guard < 5000) begin
      din[d]  = wr_q[0];
      wr_n[d] = 1'b0;
      #1;
      if (!txe_n[d]) begin
        if (d == 1) model_tx(wr_q[0]);
        void'(wr_q.pop_front());
        acc++;
      end else if (acc > 0 && !saw_hi) begin
        saw_hi    = 1'b1;
        acc_at_hi = acc;
      end
      tick();
      guard++;
    end
    wr_n[d] = 1'b1;
    if (wr_q.size() != 0) begin
      chk("wr_timeout", wr_q.size(), 0);
      wr_q.delete();
    end
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] b;
    pv[0] = '{1'b0, 1'b0, 1'b0, 1'b1};
    pv[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    pv[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
    pv[3] = '{1'b0, 1'b1, 1'b1, 1'b0};
    pv[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    pv[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
    pv[6] = '{1'b1, 1'b1, 1'b0, 1'b0};
    pv[7] = '{1'b1, 1'b1, 1'b1, 1'b0};
    m_exp = 8'h00; m_mm = 16'd0; m_txn = 32'd0;
    for (int d = 0; d < 3; d++) begin
      rst[d] = 1'b1; ft_rst_n[d] = 1'b1; oe_n[d] = 1'b1; rd_n[d] = 1'b1;
      wr_n[d] = 1'b1; siwu[d] = 1'b0; din[d] = 8'h00;
    end
    oe_n[0] = 1'b0;

    // Reset state, with the FPGA already requesting the bus.
    ticks(2);
    chk("rst_rxf_n", 32'(rxf_n[0]), 32'd1);
    chk("rst_txe_n", 32'(txe_n[0]), 32'd1);
    chk("rst_data_oe", 32'(doe[0]), 32'd0);
    chk("rst_data", 32'(dout[0]), 32'd0);
    chk("rst_rx_count", rxc[0], 32'd0);
    chk("rst_tx_count", txc[0], 32'd0);
    chk("rst_mismatch", 32'(mmc[0]), 32'd0);
    chk("rst_proto", 32'(perr[0]), 32'd0);
    for (int d = 0; d < 3; d++) rst[d] = 1'b0;
    c_phase = 0;

    // Pattern read: 20 bytes from SEED 10h.
    tick();
    for (int i = 0; i < 20; i++) exp_q.push_back(8'h10 + 8'(i));
    read_bytes(0, 20, 1'b0);
    chk("rd20_count", rxc[0], 32'd20);
    chk("rd20_proto", 32'(perr[0]), 32'd0);

    // Sticky protocol error from rd_n with oe_n high.
    oe_n[0] = 1'b1; rd_n[0] = 1'b0;
    tick();
    rd_n[0] = 1'b1;
    chk("proto_set", 32'(perr[0]), 32'd1);
    ticks(3);
    chk("proto_sticky", 32'(perr[0]), 32'd1);

    // Reset in the middle of a read burst.
    oe_n[0] = 1'b0; rd_n[0] = 1'b0;
    ticks(3);
    rst[0] = 1'b1;
    tick();
    chk("midrst_rxf_n", 32'(rxf_n[0]), 32'd1);
    chk("midrst_data_oe", 32'(doe[0]), 32'd0);
    chk("midrst_rx_count", rxc[0], 32'd0);
    chk("midrst_proto", 32'(perr[0]), 32'd0);
    rst[0] = 1'b0; oe_n[0] = 1'b1; rd_n[0] = 1'b1;

    // Protocol-violation truth table.
    for (int v = 0; v < 8; v++) begin
      do_reset(0);
      oe_n[0] = pv[v].oe_n; rd_n[0] = pv[v].rd_n; wr_n[0] = pv[v].wr_n;
      tick();
      oe_n[0] = 1'b1; rd_n[0] = 1'b1; wr_n[0] = 1'b1;
      tick();
      chk($sformatf("proto_vec%0d", v), 32'(perr[0]), 32'(pv[v].err));
    end

    // Random read strobes against the pattern sequence.
    do_reset(0);
    for (int i = 0; i < 60; i++) exp_q.push_back(8'h10 + 8'(i));
    read_bytes(0, 60, 1'b1);
    chk("rnd_rd_count", rxc[0], 32'd60);
    oe_n[0] = 1'b1;

    // Full 00h..FFh write burst with back-pressure.
    saw_hi = 1'b0; acc_at_hi = 0;
    for (int i = 0; i < 256; i++) wr_q.push_back(8'(i));
    write_q(1);
    chk("burst_txe_seen", 32'(saw_hi), 32'd1);
    chk("burst_txe_not_early", 32'(acc_at_hi >= 15), 32'd1);
    ticks(80);
    chk("burst_tx_count", txc[1], 32'd256);
    chk("burst_tx_model", txc[1], m_txn);
    chk("burst_mismatch", 32'(mmc[1]), 32'(m_mm));
    chk("burst_txe_idle", 32'(txe_n[1]), 32'd0);

    // Checker resync: 00 01 05 06 then 07.
    wr_q = '{8'h00, 8'h01, 8'h05, 8'h06};
    write_q(1);
    ticks(30);
    chk("resync_mismatch", 32'(mmc[1]), 32'(m_mm));
    wr_q = '{8'h07};
    write_q(1);
    ticks(20);
    chk("resync_hold", 32'(mmc[1]), 32'(m_mm));

    // Random mix of in-sequence and corrupted bytes.
    p = m_exp;
    for (int i = 0; i < 40; i++) begin
      b = ($urandom_range(0, 3) == 0) ? 8'($urandom) : p;
      wr_q.push_back(b);
      p = b + 8'd1;
    end
    write_q(1);
    ticks(80);
    chk("rnd_mismatch", 32'(mmc[1]), 32'(m_mm));
    chk("rnd_tx_count", txc[1], m_txn);

    // Device reset with bytes buffered both ways.
    for (int i = 0; i < 10; i++) exp_q.push_back(8'(i));
    read_bytes(1, 10, 1'b0);
    oe_n[1] = 1'b1;
    for (int i = 0; i < 10; i++) wr_q.push_back(8'h80 + 8'(i));
    write_q(1);
    ft_rst_n[1] = 1'b0;
    tick();
    chk("ftrst_rxf_n", 32'(rxf_n[1]), 32'd1);
    chk("ftrst_txe_n", 32'(txe_n[1]), 32'd1);
    chk("ftrst_rx_count", rxc[1], 32'd0);
    chk("ftrst_tx_count", txc[1], 32'd0);
    chk("ftrst_mismatch", 32'(mmc[1]), 32'd0);
    ft_rst_n[1] = 1'b1;
    m_exp = 8'h00; m_mm = 16'd0; m_txn = 32'd0;
    tick();
    exp_q.push_back(8'h00);
    read_bytes(1, 1, 1'b0);
    oe_n[1] = 1'b1;
    wr_q = '{8'h00, 8'h01, 8'h02};
    write_q(1);
    ticks(40);
    chk("ftrst_tx_after", txc[1], 32'd3);
    chk("ftrst_mm_after", 32'(mmc[1]), 32'(m_mm));

    // Loopback under periodic stalls.
    c_chk = 1'b1;
    for (int i = 0; i < 64; i++) wr_q.push_back(8'hAA ^ 8'(i));
    write_q(2);
    for (int i = 0; i < 64; i++) exp_q.push_back(8'hAA ^ 8'(i));
    read_bytes(2, 64, 1'b0);
    oe_n[2] = 1'b1;
    ticks(20);
    c_chk = 1'b0;
    chk("loop_tx_count", txc[2], 32'd64);
    chk("loop_rx_count", rxc[2], 32'd64);
    chk("loop_drained", 32'(rxf_n[2]), 32'd1);
    chk("loop_proto", 32'(perr[2]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
